// File: rtl/xgmii_pkg.sv
// Shared XGMII receive types, control characters and helpers.
// Used by xgmii_rx_tstamp and xgmii_term_find.
package xgmii_pkg;

  localparam logic [7:0] XGMII_START     = 8'hFB;
  localparam logic [7:0] XGMII_TERMINATE = 8'hFD;
  localparam logic [7:0] XGMII_ERROR     = 8'hFE;
  localparam logic [7:0] XGMII_IDLE      = 8'h07;
  localparam logic [7:0] XGMII_PREAMBLE  = 8'h55;
  localparam logic [7:0] XGMII_SFD       = 8'hD5;

  localparam int REC_TS_W  = 64;
  localparam int REC_LEN_W = 16;

  typedef struct packed {
    logic [7:0][7:0] data;
    logic [7:0]      ctrl;
  } xgmii_t;

  typedef enum logic {
    RX_IDLE,
    RX_DATA
  } rx_state_t;

  typedef struct packed {
    logic [REC_TS_W-1:0]  tstamp;
    logic [REC_LEN_W-1:0] len;
    logic [3:0]           err;
  } rx_rec_t;

  // Length add that sticks at all-ones instead of wrapping.
  function automatic logic [REC_LEN_W-1:0] len_add(
    input logic [REC_LEN_W-1:0] a,
    input logic [3:0]           b
  );
    logic [REC_LEN_W:0] s;
    s = {1'b0, a} + {{(REC_LEN_W-3){1'b0}}, b};
    return s[REC_LEN_W] ? '1 : s[REC_LEN_W-1:0];
  endfunction

endpackage

// File: rtl/xgmii_rx_tstamp_if.sv
// Per-frame record handshake between the receive
// timestamper (master) and the timestamp logger (slave).
interface xgmii_rx_tstamp_if #(
  parameter int TS_W  = 64,
  parameter int LEN_W = 16
);

  logic             rec_valid;
  logic             rec_ready;
  logic [TS_W-1:0]  rec_tstamp;
  logic [LEN_W-1:0] rec_len;
  logic [3:0]       rec_err;

  modport master (
    output rec_valid,
    output rec_tstamp,
    output rec_len,
    output rec_err,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_tstamp,
    input  rec_len,
    input  rec_err,
    output rec_ready
  );

endinterface

// File: rtl/xgmii_term_find.sv
// Finds the lowest control lane of an XGMII word and
// reports whether that lane carries Terminate.
module xgmii_term_find
  import xgmii_pkg::*;
(
  input  logic [7:0]      ctrl,
  input  logic [7:0][7:0] data,
  output logic            found,
  output logic [2:0]      lane,
  output logic            is_term
);

  // Priority scan from lane 7 down so the lowest set lane wins.
  always_comb begin
    found   = 1'b0;
    lane    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ctrl[i]) begin
        found = 1'b1;
        lane  = 3'(i);
      end
    end
    is_term = found && (data[lane] == XGMII_TERMINATE);
  end

endmodule

// File: rtl/xgmii_rx_tstamp.sv
// XGMII receive frame timestamper: one record per frame.
// Optional macro XGMII_RX_TSTAMP_RUNT_FILTER_EN drops clean runts.
module xgmii_rx_tstamp
  import xgmii_pkg::*;
#(
  parameter int TS_W    = 64,
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 9600
) (
  input  logic               xgmii_rx_clk,
  input  logic               sys_rst_n,
  input  xgmii_t             xgmii_rxi,
  input  logic [TS_W-1:0]    tsc_i,
  xgmii_rx_tstamp_if.master  rec,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        drop_cnt
`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
  ,
  output logic [15:0]        runt_cnt
`endif
);

  localparam logic [REC_LEN_W-1:0] MAX_L =
    REC_LEN_W'(MAX_LEN);

  rx_state_t             state_q, state_d;
  logic [REC_TS_W-1:0]   ts_q, ts_d;
  logic [REC_LEN_W-1:0]  len_q, len_d;
  logic                  pre_q, pre_d;
  logic                  ctl_q, ctl_d;

  rx_rec_t               held_q;
  logic                  valid_q;

  logic                  found;
  logic [2:0]            lane;
  logic                  is_term;
  logic                  start_w;
  logic                  pre_bad;
  logic                  emit;
  logic                  keep;
  rx_rec_t               emit_rec;
  logic [REC_LEN_W-1:0]  fin_len;
  logic                  load;
  logic                  drop;

  xgmii_term_find u_find (
    .ctrl    (xgmii_rxi.ctrl),
    .data    (xgmii_rxi.data),
    .found   (found),
    .lane    (lane),
    .is_term (is_term)
  );

  // Start detection and preamble/SFD check on the Start word.
  always_comb begin
    start_w = xgmii_rxi.ctrl[0] &&
              (xgmii_rxi.data[0] == XGMII_START);
    pre_bad = 1'b0;
    if (xgmii_rxi.ctrl != 8'h01)
      pre_bad = 1'b1;
    for (int i = 1; i < 7; i++)
      if (xgmii_rxi.data[i] != XGMII_PREAMBLE)
        pre_bad = 1'b1;
    if (xgmii_rxi.data[7] != XGMII_SFD)
      pre_bad = 1'b1;
  end

  // Frame FSM next state, accumulator update and emit decision.
  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q;
    len_d    = len_q;
    pre_d    = pre_q;
    ctl_d    = ctl_q;
    emit     = 1'b0;
    emit_rec = '0;
    fin_len  = len_add(len_q, {1'b0, lane});
    unique case (state_q)
      RX_IDLE: begin
        if (start_w) begin
          state_d = RX_DATA;
          ts_d    = REC_TS_W'(tsc_i);
          len_d   = '0;
          pre_d   = pre_bad;
          ctl_d   = 1'b0;
        end
      end
      RX_DATA: begin
        if (!found) begin
          len_d = len_add(len_q, 4'd8);
        end else if (is_term) begin
          emit            = 1'b1;
          emit_rec.tstamp = ts_q;
          emit_rec.len    = fin_len;
          emit_rec.err    = {fin_len > MAX_L,
                             1'b0, ctl_q, pre_q};
          state_d         = RX_IDLE;
        end else if (start_w) begin
          emit            = 1'b1;
          emit_rec.tstamp = ts_q;
          emit_rec.len    = len_q;
          emit_rec.err    = {len_q > MAX_L,
                             1'b1, ctl_q, pre_q};
          ts_d            = REC_TS_W'(tsc_i);
          len_d           = '0;
          pre_d           = pre_bad;
          ctl_d           = 1'b0;
        end else begin
          ctl_d = 1'b1;
          len_d = len_add(len_q, 4'd8);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
  logic runt;
  // Clean frames shorter than a minimum Ethernet frame are counted, not sent.
  always_comb begin
    runt = emit && (emit_rec.len < 16'd64) &&
           (emit_rec.err == 4'd0);
    keep = emit && !runt;
  end
`else
  // Every parsed frame produces a record.
  always_comb keep = emit;
`endif

  // Load into the output slot when it is empty or being drained.
  always_comb begin
    load = keep && (!valid_q || rec.rec_ready);
    drop = keep && valid_q && !rec.rec_ready;
  end

  // Frame FSM and accumulator registers.
  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= RX_IDLE;
      ts_q    <= '0;
      len_q   <= '0;
      pre_q   <= 1'b0;
      ctl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      len_q   <= len_d;
      pre_q   <= pre_d;
      ctl_q   <= ctl_d;
    end
  end

  // Held record, handshake and statistics counters.
  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      held_q    <= '0;
      valid_q   <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (load) begin
        held_q    <= emit_rec;
        valid_q   <= 1'b1;
        frame_cnt <= frame_cnt + 32'd1;
      end else if (valid_q && rec.rec_ready) begin
        valid_q <= 1'b0;
      end
      if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
  // Saturating count of suppressed runts.
  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      runt_cnt <= '0;
    else if (runt && (runt_cnt != 16'hFFFF))
      runt_cnt <= runt_cnt + 16'd1;
  end
`endif

  assign rec.rec_valid  = valid_q;
  assign rec.rec_tstamp = TS_W'(held_q.tstamp);
  assign rec.rec_len    = LEN_W'(held_q.len);
  assign rec.rec_err    = held_q.err;

endmodule

// File: tb/tb_xgmii_rx_tstamp.sv
// Directed testbench for xgmii_rx_tstamp.
// Covers reset, parsing, errors, handshake and saturation.
module tb_xgmii_rx_tstamp;
  import xgmii_pkg::*;

  logic        clk;
  logic        rst_n;
  xgmii_t      rxi;
  logic [63:0] tsc;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;
`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
  logic [15:0] runt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  xgmii_rx_tstamp_if #(.TS_W(64), .LEN_W(16)) rif ();

  xgmii_rx_tstamp dut (
    .xgmii_rx_clk (clk),
    .sys_rst_n    (rst_n),
    .xgmii_rxi    (rxi),
    .tsc_i        (tsc),
    .rec          (rif.master),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
    ,
    .runt_cnt     (runt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic put(input logic [7:0] c, input logic [63:0] d);
    @(negedge clk);
    rxi.ctrl = c;
    rxi.data = d;
  endtask

  task automatic send_idle();
    put(8'hFF, 64'h0707070707070707);
  endtask

  task automatic send_start(input logic [63:0] ts, input bit bad);
    logic [63:0] d;
    d = 64'hD5555555555555FB;
    if (bad) d[31:24] = 8'h54;
    @(negedge clk);
    tsc = ts;
    rxi.ctrl = 8'h01;
    rxi.data = d;
  endtask

  task automatic send_data(input int n);
    for (int k = 0; k < n; k++)
      put(8'h00, 64'h0123456789ABCDEF);
  endtask

  task automatic send_term(input int lane);
    logic [7:0] c;
    logic [7:0][7:0] d;
    for (int i = 0; i < 8; i++) begin
      if (i < lane) begin
        c[i] = 1'b0; d[i] = 8'hAA;
      end else if (i == lane) begin
        c[i] = 1'b1; d[i] = XGMII_TERMINATE;
      end else begin
        c[i] = 1'b1; d[i] = XGMII_IDLE;
      end
    end
    put(c, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rif.rec_ready = 1'b1;
    tsc = 64'd0;
    rxi.ctrl = 8'hFF;
    rxi.data = 64'h0707070707070707;
    repeat (3) @(negedge clk);
    checks++;
    if (rif.rec_valid !== 1'b0 || frame_cnt !== 32'd0 ||
        drop_cnt !== 16'd0 || rif.rec_len !== 16'd0 ||
        rif.rec_tstamp !== 64'd0 || rif.rec_err !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b fc=%0d dc=%0d len=%0d ts=%0d err=%h required all 0",
               rif.rec_valid, frame_cnt, drop_cnt, rif.rec_len,
               rif.rec_tstamp, rif.rec_err);
    end
    rst_n = 1'b1;
    send_idle();
  endtask

  task automatic test_good_frame();
    send_start(64'd1000, 1'b0);
    send_data(7);
    send_term(4);
    checks++;
    if (rif.rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_early_valid got %0b required 0", rif.rec_valid);
    end
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_tstamp !== 64'd1000) begin
      errors++;
      $display("FAIL good_valid_ts got v=%0b ts=%0d required v=1 ts=1000",
               rif.rec_valid, rif.rec_tstamp);
    end
    checks++;
    if (rif.rec_len !== 16'd60 || rif.rec_err !== 4'd0) begin
      errors++;
      $display("FAIL good_len_err got len=%0d err=%h required len=60 err=0",
               rif.rec_len, rif.rec_err);
    end
    checks++;
    if (frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL good_frame_cnt got %0d required 1", frame_cnt);
    end
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_accept got v=%0b required 0", rif.rec_valid);
    end
  endtask

  task automatic test_bad_preamble();
    send_start(64'd1100, 1'b1);
    send_data(2);
    send_term(3);
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_len !== 16'd19 ||
        rif.rec_err !== 4'b0001 || rif.rec_tstamp !== 64'd1100) begin
      errors++;
      $display("FAIL bad_pre got v=%0b len=%0d err=%h ts=%0d required v=1 len=19 err=1 ts=1100",
               rif.rec_valid, rif.rec_len, rif.rec_err, rif.rec_tstamp);
    end
    send_idle();
  endtask

  task automatic test_ctrl_error();
    send_start(64'd1200, 1'b0);
    send_data(2);
    put(8'h04, 64'h0000000000FE0000);
    send_data(1);
    send_term(0);
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_len !== 16'd32 ||
        rif.rec_err !== 4'b0010) begin
      errors++;
      $display("FAIL ctrl_err got v=%0b len=%0d err=%h required v=1 len=32 err=2",
               rif.rec_valid, rif.rec_len, rif.rec_err);
    end
    checks++;
    if (frame_cnt !== 32'd3) begin
      errors++;
      $display("FAIL ctrl_frame_cnt got %0d required 3", frame_cnt);
    end
    send_idle();
  endtask

  task automatic test_truncated();
    send_start(64'd1500, 1'b0);
    send_data(2);
    send_start(64'd2000, 1'b0);
    send_data(1);
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_len !== 16'd16 ||
        rif.rec_err !== 4'b0100 || rif.rec_tstamp !== 64'd1500) begin
      errors++;
      $display("FAIL trunc_rec got v=%0b len=%0d err=%h ts=%0d required v=1 len=16 err=4 ts=1500",
               rif.rec_valid, rif.rec_len, rif.rec_err, rif.rec_tstamp);
    end
    send_data(2);
    send_term(1);
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_len !== 16'd25 ||
        rif.rec_err !== 4'd0 || rif.rec_tstamp !== 64'd2000) begin
      errors++;
      $display("FAIL trunc_next got v=%0b len=%0d err=%h ts=%0d required v=1 len=25 err=0 ts=2000",
               rif.rec_valid, rif.rec_len, rif.rec_err, rif.rec_tstamp);
    end
    send_idle();
  endtask

  task automatic test_back_to_back();
    rif.rec_ready = 1'b0;
    send_start(64'd3000, 1'b0);
    send_data(1);
    send_term(0);
    send_start(64'd3100, 1'b0);
    send_data(2);
    send_term(2);
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_tstamp !== 64'd3000 ||
        rif.rec_len !== 16'd8) begin
      errors++;
      $display("FAIL held_rec got v=%0b ts=%0d len=%0d required v=1 ts=3000 len=8",
               rif.rec_valid, rif.rec_tstamp, rif.rec_len);
    end
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_cnt got %0d required 1", drop_cnt);
    end
    send_start(64'd3200, 1'b0);
    send_data(1);
    send_term(5);
    rif.rec_ready = 1'b1;
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_tstamp !== 64'd3000) begin
      errors++;
      $display("FAIL held_before_accept got v=%0b ts=%0d required v=1 ts=3000",
               rif.rec_valid, rif.rec_tstamp);
    end
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || rif.rec_tstamp !== 64'd3200 ||
        rif.rec_len !== 16'd13) begin
      errors++;
      $display("FAIL no_bubble got v=%0b ts=%0d len=%0d required v=1 ts=3200 len=13",
               rif.rec_valid, rif.rec_tstamp, rif.rec_len);
    end
    checks++;
    if (frame_cnt !== 32'd7) begin
      errors++;
      $display("FAIL b2b_frame_cnt got %0d required 7", frame_cnt);
    end
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got v=%0b required 0", rif.rec_valid);
    end
  endtask

  task automatic test_long();
    send_start(64'd6000, 1'b0);
    send_data(1200);
    send_term(0);
    send_idle();
    checks++;
    if (rif.rec_len !== 16'd9600 || rif.rec_err !== 4'd0) begin
      errors++;
      $display("FAIL len_at_max got len=%0d err=%h required len=9600 err=0",
               rif.rec_len, rif.rec_err);
    end
    send_start(64'd6100, 1'b0);
    send_data(1200);
    send_term(1);
    send_idle();
    checks++;
    if (rif.rec_len !== 16'd9601 || rif.rec_err !== 4'b1000) begin
      errors++;
      $display("FAIL len_over_max got len=%0d err=%h required len=9601 err=8",
               rif.rec_len, rif.rec_err);
    end
    send_start(64'd6200, 1'b0);
    send_data(8200);
    send_term(0);
    send_idle();
    checks++;
    if (rif.rec_len !== 16'hFFFF || rif.rec_err !== 4'b1000 ||
        rif.rec_tstamp !== 64'd6200) begin
      errors++;
      $display("FAIL len_saturate got len=%0d err=%h ts=%0d required len=65535 err=8 ts=6200",
               rif.rec_len, rif.rec_err, rif.rec_tstamp);
    end
    send_idle();
  endtask

  task automatic test_mid_reset();
    rif.rec_ready = 1'b0;
    send_start(64'd4000, 1'b0);
    send_data(1);
    send_term(0);
    send_start(64'd4100, 1'b0);
    send_data(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rif.rec_valid !== 1'b0 || frame_cnt !== 32'd0 ||
        drop_cnt !== 16'd0 || rif.rec_len !== 16'd0 ||
        rif.rec_tstamp !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%0b fc=%0d dc=%0d len=%0d ts=%0d required all 0",
               rif.rec_valid, frame_cnt, drop_cnt, rif.rec_len,
               rif.rec_tstamp);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    rif.rec_ready = 1'b1;
    send_data(2);
    send_term(3);
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_after_reset got v=%0b required 0", rif.rec_valid);
    end
    send_start(64'd5000, 1'b0);
    send_data(8);
    send_term(0);
    send_idle();
    checks++;
    if (rif.rec_valid !== 1'b1 || frame_cnt !== 32'd1 ||
        rif.rec_len !== 16'd64 || rif.rec_tstamp !== 64'd5000) begin
      errors++;
      $display("FAIL clean_after_reset got v=%0b fc=%0d len=%0d ts=%0d required v=1 fc=1 len=64 ts=5000",
               rif.rec_valid, frame_cnt, rif.rec_len, rif.rec_tstamp);
    end
    send_idle();
  endtask

`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
  task automatic test_runt();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_start(64'd7000, 1'b0);
    send_data(5);
    send_term(0);
    send_idle();
    checks++;
    if (runt_cnt !== 16'd1 || rif.rec_valid !== 1'b0 ||
        frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL runt got rc=%0d v=%0b fc=%0d required rc=1 v=0 fc=0",
               runt_cnt, rif.rec_valid, frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_preamble();
    test_ctrl_error();
    test_truncated();
    test_back_to_back();
    test_long();
    test_mid_reset();
`ifdef XGMII_RX_TSTAMP_RUNT_FILTER_EN
    test_runt();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/xgmii_rx_tstamp.md
Name: xgmii_rx_tstamp

Overview:
- Sits directly downstream of the XGMII receive lane aligner, whose output always places Start in lane 0.
- Parses the aligned 64-bit XGMII receive stream and checks the preamble/SFD word.
- Latches a free-running timestamp at start-of-frame and counts frame bytes up to Terminate.
- Emits one per-frame record (timestamp, length, error flags) over a valid/ready interface to the timestamp logger.

Parameters:
- TS_W, 64, width of timestamp counter input and record timestamp.
- LEN_W, 16, width of the record length field; the length saturates at the maximum value.
- MAX_LEN, 9600, byte count above which err_long is set.

Ports:
- xgmii_rx_clk  in  1  receive clock; the only clock in the block.
- sys_rst_n  in  1  asynchronous, active-low reset.
- xgmii_rxi  in  xgmii_t (8x8 data + 8 ctrl)  lane-aligned XGMII receive word.
- tsc_i  in  TS_W  free-running timestamp counter, synchronous to xgmii_rx_clk.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_tstamp  out  TS_W  tsc_i sampled on the Start word.
- rec_len  out  LEN_W  bytes after SFD up to but excluding Terminate (includes FCS).
- rec_err  out  4  {err_long, err_trunc, err_ctrl, err_pre}.
- frame_cnt  out  32  records emitted, wrapping.
- drop_cnt  out  16  records lost to backpressure, saturating.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; accumulated length, flags and timestamp cleared.
- Start word: ctrl[0]=1 and data[0]=XGMII_START.
  - Good preamble: ctrl=8'h01, data lanes 1..6 = 8'h55, lane 7 = 8'hD5.
- IDLE:
  - On a Start word: go to DATA; capture tsc_i in the same cycle; clear length.
  - err_pre = 1 if the preamble is not good; the frame is still tracked to Terminate.
  - All other words are ignored.
- DATA, for each word:
  - Find i = the lowest lane with ctrl set.
  - No ctrl lane: length += 8.
  - data[i]=XGMII_TERMINATE: length += i, emit the record, go to IDLE. Lanes after i are ignored.
  - Start in lane 0: emit the current record with err_trunc=1. In the same cycle, begin the new frame as in IDLE, capturing tsc_i.
  - Any other ctrl char (incl. XGMII_ERROR) in any lane: err_ctrl=1, length += 8, stay in DATA.
- Length arithmetic: saturating add at 2^LEN_W-1. err_long is set once length > MAX_LEN.
- Emit timing:
  - Record outputs are registered; rec_valid rises 1 cycle after the terminating word is on xgmii_rxi.
  - frame_cnt increments in the emit cycle.
- Handshake:
  - A record holds stable while rec_valid=1 && rec_ready=0.
  - Transfer occurs when rec_valid && rec_ready.
  - Emit while a record is held and not accepted that cycle: the new record is dropped; drop_cnt += 1 (saturating); the held record is unchanged.
  - Emit in the same cycle as acceptance: the new record loads with no bubble; rec_valid stays 1.
- Reset mid-frame: the frame is abandoned, no record is emitted, and the held record is lost.

Optional Feature:
- Macro XGMII_RX_TSTAMP_RUNT_FILTER_EN.
- Defined: records with rec_len < 64 and no err_* flag set are suppressed. They do not touch rec_valid or frame_cnt and instead increment output runt_cnt (16-bit, saturating, port present only under the macro).
- Undefined: all records are emitted; no runt_cnt port.

Decomposition:
- xgmii_pkg gains:
  - XGMII_TERMINATE (8'hFD), XGMII_ERROR (8'hFE), XGMII_IDLE (8'h07), XGMII_PREAMBLE (8'h55), XGMII_SFD (8'hD5).
  - rx_state_t enum {RX_IDLE, RX_DATA}.
  - rx_rec_t struct {tstamp, len, err}.
- Sub-module xgmii_term_find: combinational. Takes ctrl/data and returns a found flag, the 3-bit lane index of the first ctrl lane, and an is_terminate flag.

Test Plan:
- Good frame, tsc_i=1000 at Start, 7 full data words, then Terminate in lane 4 -> one record: tstamp=1000, len=60, err=0, rec_valid 1 cycle after the T word, frame_cnt=1.
- Start word with lane 3 = 8'h54 -> err_pre=1; frame continues; len counted normally.
- XGMII_ERROR in lane 2 of data word 3 -> err_ctrl=1; len includes that lane.
- New Start (tsc_i=2000) with no Terminate after 2 data words -> first record len=16, err_trunc=1; second record tstamp=2000.
- rec_ready=0 across two complete frames -> first record held unchanged, drop_cnt=1; rec_ready=1 accepts the first; rec_valid=1 with simultaneous emit loads the next without a gap.
- Assert sys_rst_n=0 mid-frame and mid-held-record -> all outputs 0 immediately; the next clean frame yields frame_cnt=1. With XGMII_RX_TSTAMP_RUNT_FILTER_EN, a 40-byte frame gives runt_cnt=1 and no rec_valid.
